// File: rtl/clock_time_base_if.sv
// Key/switch inputs and time-of-day outputs of clock_time_base.
// Alarm inputs exist only when CLOCK_ALARM_EN is defined.
interface clock_time_base_if;
  logic       enable;
  logic       incMinutes;
  logic       incHours;
  logic       mode12h;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       pm;
  logic       secondTick;
  logic       alarm;
`ifdef CLOCK_ALARM_EN
  logic       alarmEnable;
  logic [4:0] alarmHours;
  logic [5:0] alarmMinutes;
`endif

  modport master (
`ifdef CLOCK_ALARM_EN
    output alarmEnable, alarmHours, alarmMinutes,
`endif
    output enable, incMinutes, incHours, mode12h,
    input  seconds, minutes, hours, pm, secondTick, alarm
  );

  modport slave (
`ifdef CLOCK_ALARM_EN
    input  alarmEnable, alarmHours, alarmMinutes,
`endif
    input  enable, incMinutes, incHours, mode12h,
    output seconds, minutes, hours, pm, secondTick, alarm
  );
endinterface

// File: rtl/clock_time_base.sv
// Time-of-day core: prescaler, hh:mm:ss carry chain, 12/24 h display, set-button auto-repeat.
// Optional alarm comparator enabled by defining CLOCK_ALARM_EN.
module clock_time_base #(
  parameter int ClockFrequency = 24_000_000,
  parameter int RepeatDelay    = 12_000_000,
  parameter int RepeatPeriod   = 2_400_000
) (
  input  logic              clock,
  input  logic              reset,
  clock_time_base_if.slave  bus
);
  localparam int PRE_W   = (ClockFrequency > 1) ? $clog2(ClockFrequency) : 1;
  localparam int RPT_MAX = (RepeatDelay > RepeatPeriod) ? RepeatDelay : RepeatPeriod;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(ClockFrequency - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(RepeatDelay - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(RepeatPeriod - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_e;

  logic [1:0] btn;
  logic [1:0] rpt_pulse;
  assign btn = {bus.incHours, bus.incMinutes};

  // Set-button repeat FSMs: bit 0 = minutes, bit 1 = hours
  for (genvar g = 0; g < 2; g++) begin : g_rpt
    rpt_state_e       state_q;
    logic [RPT_W-1:0] cnt_q;
    logic             pulse_q;

    always_ff @(posedge clock) begin
      if (!reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        if (!btn[g]) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          case (state_q)
            IDLE: begin
              state_q <= DELAY;
              cnt_q   <= '0;
              pulse_q <= 1'b1;
            end
            DELAY: begin
              if (cnt_q == DELAY_LAST) begin
                state_q <= REPEAT;
                cnt_q   <= '0;
                pulse_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
            REPEAT: begin
              if (cnt_q == PERIOD_LAST) begin
                cnt_q   <= '0;
                pulse_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
            default: begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          endcase
        end
      end
    end

    assign rpt_pulse[g] = pulse_q;
  end

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [5:0]       sec_q, sec_d;
  logic [5:0]       min_q, min_d;
  logic [4:0]       h24_q, h24_d;
  logic             tick_out_q, tick_out_d;
  logic             tick;

  assign tick = bus.enable && (pre_q == PRE_LAST);

  // A set pulse takes priority and swallows a coincident tick
  always_comb begin
    pre_d      = pre_q;
    sec_d      = sec_q;
    min_d      = min_q;
    h24_d      = h24_q;
    tick_out_d = 1'b0;
    if (rpt_pulse != 2'b00) begin
      pre_d = '0;
      sec_d = '0;
      if (rpt_pulse[0]) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      if (rpt_pulse[1]) h24_d = (h24_q == 5'd23) ? 5'd0 : h24_q + 5'd1;
    end else if (tick) begin
      pre_d      = '0;
      tick_out_d = 1'b1;
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          h24_d = (h24_q == 5'd23) ? 5'd0 : h24_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else if (bus.enable) begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pre_q      <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      h24_q      <= '0;
      tick_out_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      h24_q      <= h24_d;
      tick_out_q <= tick_out_d;
    end
  end

  logic [4:0] h12;
  always_comb begin
    h12 = (h24_q >= 5'd12) ? h24_q - 5'd12 : h24_q;
    if (h12 == 5'd0) h12 = 5'd12;
  end

  assign bus.seconds    = sec_q;
  assign bus.minutes    = min_q;
  assign bus.hours      = bus.mode12h ? h12 : h24_q;
  assign bus.pm         = (h24_q >= 5'd12);
  assign bus.secondTick = tick_out_q;

`ifdef CLOCK_ALARM_EN
  logic alarm_q, alarm_d;
  assign alarm_d = bus.alarmEnable && (h24_q == bus.alarmHours) && (min_q == bus.alarmMinutes);

  always_ff @(posedge clock) begin
    if (!reset) alarm_q <= 1'b0;
    else        alarm_q <= alarm_d;
  end

  assign bus.alarm = alarm_q;
`else
  assign bus.alarm = 1'b0;
`endif
endmodule

// File: tb/tb_clock_time_base.sv
// Randomised scoreboard bench for clock_time_base; time kept as seconds-of-day in the model.
module tb_clock_time_base;
  localparam int CF = 10;
  localparam int RD = 20;
  localparam int RP = 5;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  clock_time_base_if bus ();

  clock_time_base #(
    .ClockFrequency(CF),
    .RepeatDelay   (RD),
    .RepeatPeriod  (RP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hrs;
    logic       pm;
    logic       tick;
    logic       alarm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: value the DUT should hold after the coming edge
  int m_tod = 0;
  int m_pre = 0;
  bit m_tick = 0;
  bit m_alarm = 0;
  int m_hold[2] = '{0, 0};
  bit m_pulse[2] = '{0, 0};
  bit a_en = 0;
  int a_h = 0;
  int a_m = 0;

  task automatic model_step(input bit rst_n, input bit en, input bit im, input bit ih);
    bit np[2];
    bit b[2];
    int h, m;
    b[0] = im;
    b[1] = ih;
    h = m_tod / 3600;
    m = (m_tod / 60) % 60;
    if (!rst_n) begin
      m_tod = 0; m_pre = 0; m_tick = 0; m_alarm = 0;
      m_hold = '{0, 0};
      m_pulse = '{0, 0};
    end else begin
`ifdef CLOCK_ALARM_EN
      m_alarm = a_en && (h == a_h) && (m == a_m);
`else
      m_alarm = 0;
`endif
      for (int i = 0; i < 2; i++) begin
        if (b[i]) begin
          np[i] = (m_hold[i] == 0) || (m_hold[i] >= RD && ((m_hold[i] - RD) % RP) == 0);
          m_hold[i]++;
        end else begin
          np[i] = 0;
          m_hold[i] = 0;
        end
      end
      if (m_pulse[0] || m_pulse[1]) begin
        if (m_pulse[0]) m = (m + 1) % 60;
        if (m_pulse[1]) h = (h + 1) % 24;
        m_tod = h * 3600 + m * 60;
        m_pre = 0;
        m_tick = 0;
      end else if (en && m_pre == CF - 1) begin
        m_tod = (m_tod + 1) % 86400;
        m_pre = 0;
        m_tick = 1;
      end else begin
        m_tick = 0;
        if (en) m_pre++;
      end
      m_pulse = np;
    end
  endtask

  task automatic cyc(input bit rst_n, input bit en, input bit im, input bit ih, input bit md);
    exp_t e;
    int h;
    reset          = rst_n;
    bus.enable     = en;
    bus.incMinutes = im;
    bus.incHours   = ih;
    bus.mode12h    = md;
`ifdef CLOCK_ALARM_EN
    bus.alarmEnable  = a_en;
    bus.alarmHours   = 5'(a_h);
    bus.alarmMinutes = 6'(a_m);
`endif
    model_step(rst_n, en, im, ih);
    h = m_tod / 3600;
    e.sec   = 6'(m_tod % 60);
    e.min   = 6'((m_tod / 60) % 60);
    e.hrs   = md ? 5'(((h % 12) == 0) ? 12 : (h % 12)) : 5'(h);
    e.pm    = (h >= 12);
    e.tick  = m_tick;
    e.alarm = m_alarm;
    exp_q.push_back(e);
    @(posedge clock);
    @(negedge clock);
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL no_expectation @%0t: DUT output present with empty scoreboard", $time);
      end else begin
        e = exp_q.pop_front();
        if (bus.seconds !== e.sec || bus.minutes !== e.min || bus.hours !== e.hrs ||
            bus.pm !== e.pm || bus.secondTick !== e.tick || bus.alarm !== e.alarm) begin
          errors++;
          $display("FAIL outputs @%0t: got s=%0d m=%0d h=%0d pm=%0b tick=%0b alarm=%0b, expected s=%0d m=%0d h=%0d pm=%0b tick=%0b alarm=%0b",
                   $time, bus.seconds, bus.minutes, bus.hours, bus.pm, bus.secondTick, bus.alarm,
                   e.sec, e.min, e.hrs, e.pm, e.tick, e.alarm);
        end
      end
    end
  end

  initial begin
    bit hm, hh, rn, en, md;
    // Reset, then free run through minute 2 with the alarm aimed at 00:02
    repeat (3) cyc(0, 1, 0, 0, 0);
    a_en = 1; a_h = 0; a_m = 2;
    repeat (1300) cyc(1, 1, 0, 0, 0);
    a_en = 0;

    // Preset 23:59:xx with time frozen, then roll over midnight
    for (int k = 0; k < 30 && (m_tod / 3600) != 23; k++) begin
      cyc(1, 0, 0, 1, 0);
      cyc(1, 0, 0, 0, 0);
    end
    for (int k = 0; k < 70 && ((m_tod / 60) % 60) != 59; k++) begin
      cyc(1, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0);
    end
    for (int k = 0; k < 700 && (m_tod % 60) != 58; k++) cyc(1, 1, 0, 0, 0);
    repeat (15) cyc(1, 1, 0, 0, 1);
    repeat (10) cyc(1, 1, 0, 0, 0);
    repeat (10) cyc(1, 1, 0, 0, 1);

    // Press-and-hold auto-repeat on minutes
    repeat (50) cyc(1, 1, 1, 0, 0);
    repeat (3) cyc(1, 1, 0, 0, 0);

    // Minutes 59 -> 0 without hour carry
    for (int k = 0; k < 70 && ((m_tod / 60) % 60) != 59; k++) begin
      cyc(1, 1, 1, 0, 0);
      cyc(1, 1, 0, 0, 0);
    end
    cyc(1, 1, 1, 0, 0);
    repeat (3) cyc(1, 1, 0, 0, 0);

    // Both set pulses land on the tick cycle
    for (int k = 0; k < 30 && m_pre != CF - 2; k++) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 0);
    repeat (4) cyc(1, 1, 0, 0, 0);

    // Reset in the middle of a hold, button stays high
    repeat (10) cyc(1, 1, 0, 1, 1);
    repeat (2) cyc(0, 1, 0, 1, 1);
    repeat (30) cyc(1, 1, 0, 1, 1);
    repeat (2) cyc(1, 1, 0, 0, 1);

    // Randomised traffic
    hm = 0; hh = 0; md = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(29) == 0) hm = ~hm;
      if ($urandom_range(29) == 0) hh = ~hh;
      if ($urandom_range(49) == 0) md = ~md;
      rn = ($urandom_range(399) != 0);
      en = ($urandom_range(9) != 0);
      if ($urandom_range(199) == 0) begin
        a_en = $urandom_range(3) != 0;
        a_h  = m_tod / 3600;
        a_m  = ((m_tod / 60) + $urandom_range(1)) % 60;
      end
      cyc(rn, en, hm, hh, md);
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
